// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer.
// Holds the FSM state encoding, the default raster size, the score and
// frame-counter widths, the per-frame event bundle and a saturating increment.
`timescale 1ns/1ps
package pong_pkg;

  localparam int X_RES_DEF = 1280;
  localparam int Y_RES_DEF = 720;
  localparam int SCORE_W   = 4;
  localparam int CNT_W     = 8;

  // Encoding is visible on o_state for the debug overlay.
  typedef enum logic [2:0] {
    st_idle      = 3'd0,
    st_serve     = 3'd1,
    st_play      = 3'd2,
    st_point     = 3'd3,
    st_game_over = 3'd4
  } state_t;

  // Events seen by the ball during one frame.
  typedef struct packed {
    logic hit;
    logic miss_l;
    logic miss_r;
  } evt_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame-tick down-counter.
// Ports: clk, rst (sync, active-high), load/load_val (load wins over tick),
//        tick (frame pulse, decrements, saturating at 0), zero (count == 0).
`timescale 1ns/1ps
module pong_frame_timer
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (tick && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-level sequencer for the pong ball sprite.
// Watches the registered draw outputs of the ball and paddles, latches
// per-frame hit/miss events, acts on them at the frame tick, keeps scores and
// steps IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER).
// Ports: clk, rst (sync, active-high); i_vcnt/i_hcnt raster counters;
//        i_start game start; i_ball_draw/i_pad_l_draw/i_pad_r_draw pixel draws
//        (one cycle behind the counters); o_ball_en ball visibility;
//        o_opposite one-cycle bounce pulse; o_score_l/o_score_r scores;
//        o_game_over; o_state debug state encoding.
`timescale 1ns/1ps
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int X_RES        = X_RES_DEF,
  parameter int Y_RES        = Y_RES_DEF,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        i_vcnt,
  input  logic [10:0]        i_hcnt,
  input  logic               i_start,
  input  logic               i_ball_draw,
  input  logic               i_pad_l_draw,
  input  logic               i_pad_r_draw,
  output logic               o_ball_en,
  output logic               o_opposite,
  output logic [SCORE_W-1:0] o_score_l,
  output logic [SCORE_W-1:0] o_score_r,
  output logic               o_game_over,
  output logic [2:0]         o_state
);

  localparam logic [10:0]        X_LAST   = 11'(X_RES - 1);
  localparam logic [10:0]        Y_LIM    = 11'(Y_RES);
  localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t             state, next_state;
  logic [10:0]        hd, vd;
  logic [SCORE_W-1:0] score_l, score_r;
  logic               opp;
  logic               start_q, start_pend;
  evt_t               lat, cur, ev;
  logic               tick, play, start_rise;
  logic               tmr_load, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;
  logic               inc_l, inc_r, clr_scores, opp_nxt;

  // Counters delayed to line up with the registered draw inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hd <= '0;
      vd <= '0;
    end else begin
      hd <= i_hcnt;
      vd <= i_vcnt;
    end
  end

  assign tick       = (i_vcnt == '0) && (i_hcnt == '0);
  assign play       = (state == st_play);
  assign start_rise = i_start && !start_q;

  // Current-pixel events, only in PLAY and inside the active area.
  always_comb begin
    cur        = '0;
    cur.hit    = play && (vd < Y_LIM) && i_ball_draw && (i_pad_l_draw || i_pad_r_draw);
    cur.miss_l = play && (vd < Y_LIM) && i_ball_draw && (hd == '0);
    cur.miss_r = play && (vd < Y_LIM) && i_ball_draw && (hd == X_LAST);
  end

  // The pixel arriving in the tick cycle belongs to the frame being closed,
  // so it is folded into the sampled events rather than lost by the clear.
  always_comb begin
    ev        = '0;
    ev.hit    = lat.hit    || cur.hit;
    ev.miss_l = lat.miss_l || cur.miss_l;
    ev.miss_r = lat.miss_r || cur.miss_r;
  end

  always_ff @(posedge clk) begin
    if (rst || tick) lat <= '0;
    else begin
      lat.hit    <= lat.hit    || cur.hit;
      lat.miss_l <= lat.miss_l || cur.miss_l;
      lat.miss_r <= lat.miss_r || cur.miss_r;
    end
  end

  pong_frame_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .zero     (tmr_zero)
  );

  always_comb begin
    next_state = state;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    clr_scores = 1'b0;
    opp_nxt    = 1'b0;
    case (state)
      st_idle: begin
        if (i_start) clr_scores = 1'b1;
        if (tick && (start_pend || i_start)) next_state = st_serve;
      end
      st_serve: if (tick && tmr_zero) next_state = st_play;
      st_play: begin
        if (tick) begin
          // Left miss wins so a double miss credits the right player once.
          if (ev.miss_l) begin
            inc_r      = 1'b1;
            next_state = st_point;
          end else if (ev.miss_r) begin
            inc_l      = 1'b1;
            next_state = st_point;
          end else if (ev.hit) begin
            opp_nxt = 1'b1;
          end
        end
      end
      st_point: begin
        if (score_l == WIN || score_r == WIN) next_state = st_game_over;
        else if (tick && tmr_zero)            next_state = st_serve;
      end
      st_game_over: if (start_rise) next_state = st_idle;
      default: next_state = st_idle;
    endcase
  end

  // Timer reloads on every state change; only SERVE and POINT use its value.
  always_comb begin
    tmr_load = (next_state != state);
    tmr_val  = '0;
    if (next_state == st_serve)      tmr_val = SERVE_LD;
    else if (next_state == st_point) tmr_val = POINT_LD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= st_idle;
      score_l    <= '0;
      score_r    <= '0;
      opp        <= 1'b0;
      start_q    <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      state   <= next_state;
      opp     <= opp_nxt;
      start_q <= i_start;
      if (clr_scores) begin
        score_l <= '0;
        score_r <= '0;
      end else begin
        if (inc_l) score_l <= sat_inc(score_l);
        if (inc_r) score_r <= sat_inc(score_r);
      end
      if (state != st_idle) start_pend <= 1'b0;
      else if (i_start)     start_pend <= 1'b1;
    end
  end

  assign o_ball_en   = play;
  assign o_opposite  = opp;
  assign o_score_l   = score_l;
  assign o_score_r   = score_r;
  assign o_game_over = (state == st_game_over);
  assign o_state     = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] i_vcnt, i_hcnt;
  logic        i_start, i_ball_draw, i_pad_l_draw, i_pad_r_draw;
  logic        o_ball_en, o_opposite, o_game_over;
  logic [3:0]  o_score_l, o_score_r;
  logic [2:0]  o_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_vcnt       (i_vcnt),
    .i_hcnt       (i_hcnt),
    .i_start      (i_start),
    .i_ball_draw  (i_ball_draw),
    .i_pad_l_draw (i_pad_l_draw),
    .i_pad_r_draw (i_pad_r_draw),
    .o_ball_en    (o_ball_en),
    .o_opposite   (o_opposite),
    .o_score_l    (o_score_l),
    .o_score_r    (o_score_r),
    .o_game_over  (o_game_over),
    .o_state      (o_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick: counters at 0,0 for one cycle.
  task automatic tick();
    i_vcnt = 11'd0;
    i_hcnt = 11'd0;
    step();
    i_vcnt = 11'd100;
    i_hcnt = 11'd100;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Ball pixel at column h on line 100; draws follow counters by one cycle.
  task automatic pix(input int h, input logic pl, input logic pr);
    i_hcnt = 11'(h);
    i_vcnt = 11'd100;
    step();
    i_hcnt       = 11'd100;
    i_ball_draw  = 1'b1;
    i_pad_l_draw = pl;
    i_pad_r_draw = pr;
    step();
    i_ball_draw  = 1'b0;
    i_pad_l_draw = 1'b0;
    i_pad_r_draw = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", o_state); end
    total++; if ({o_score_l, o_score_r} !== 8'h00) begin bad++; $display("FAIL reset_scores got=%0d/%0d want=0/0", o_score_l, o_score_r); end
    total++; if ({o_ball_en, o_opposite, o_game_over} !== 3'b000) begin bad++; $display("FAIL reset_outs got=%b want=000", {o_ball_en, o_opposite, o_game_over}); end
  endtask

  // Start pulse, IDLE until tick, SERVE, PLAY after 60 further ticks.
  task automatic test_serve(input string tag);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL %s_idle_wait got=%0d want=0", tag, o_state); end
    tick();
    total++; if (o_state !== 3'd1) begin bad++; $display("FAIL %s_serve got=%0d want=1", tag, o_state); end
    ticks(59);
    total++; if (o_state !== 3'd1 || o_ball_en !== 1'b0) begin bad++; $display("FAIL %s_serve_59 got=%0d/%b want=1/0", tag, o_state, o_ball_en); end
    tick();
    total++; if (o_state !== 3'd2 || o_ball_en !== 1'b1) begin bad++; $display("FAIL %s_play_entry got=%0d/%b want=2/1", tag, o_state, o_ball_en); end
  endtask

  task automatic test_hit();
    for (int i = 0; i < 5; i++) pix(600 + i, 1'b1, 1'b0);
    step();
    total++; if (o_opposite !== 1'b0) begin bad++; $display("FAIL hit_pre_tick got=%b want=0", o_opposite); end
    tick();
    total++; if (o_opposite !== 1'b1) begin bad++; $display("FAIL hit_pulse got=%b want=1", o_opposite); end
    step();
    total++; if (o_opposite !== 1'b0) begin bad++; $display("FAIL hit_pulse_len got=%b want=0", o_opposite); end
    tick();
    total++; if (o_opposite !== 1'b0) begin bad++; $display("FAIL hit_next_frame got=%b want=0", o_opposite); end
    total++; if ({o_score_l, o_score_r} !== 8'h00 || o_state !== 3'd2) begin bad++; $display("FAIL hit_no_score got=%0d/%0d st=%0d want=0/0 st=2", o_score_l, o_score_r, o_state); end
  endtask

  task automatic test_miss_r();
    pix(1279, 1'b0, 1'b0);
    step();
    total++; if (o_score_l !== 4'd0) begin bad++; $display("FAIL miss_r_pre got=%0d want=0", o_score_l); end
    tick();
    total++; if (o_score_l !== 4'd1 || o_score_r !== 4'd0) begin bad++; $display("FAIL miss_r_score got=%0d/%0d want=1/0", o_score_l, o_score_r); end
    total++; if (o_state !== 3'd3 || o_ball_en !== 1'b0) begin bad++; $display("FAIL miss_r_point got=%0d/%b want=3/0", o_state, o_ball_en); end
    ticks(89);
    total++; if (o_state !== 3'd3) begin bad++; $display("FAIL miss_r_point_89 got=%0d want=3", o_state); end
    tick();
    total++; if (o_state !== 3'd1) begin bad++; $display("FAIL miss_r_serve got=%0d want=1", o_state); end
  endtask

  task automatic test_reset_mid();
    ticks(3);
    i_hcnt = 11'd300;
    i_vcnt = 11'd200;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (o_state !== 3'd0) begin bad++; $display("FAIL rstmid_state got=%0d want=0", o_state); end
    total++; if ({o_score_l, o_score_r} !== 8'h00) begin bad++; $display("FAIL rstmid_scores got=%0d/%0d want=0/0", o_score_l, o_score_r); end
    total++; if (o_opposite !== 1'b0 || o_ball_en !== 1'b0) begin bad++; $display("FAIL rstmid_outs got=%b/%b want=0/0", o_opposite, o_ball_en); end
    total++; if (dut.u_timer.cnt !== 8'd0) begin bad++; $display("FAIL rstmid_timer got=%0d want=0", dut.u_timer.cnt); end
    i_hcnt = 11'd100;
    i_vcnt = 11'd100;
  endtask

  task automatic test_hit_and_miss();
    pix(0, 1'b1, 1'b0);
    tick();
    total++; if (o_opposite !== 1'b0) begin bad++; $display("FAIL hitmiss_opp got=%b want=0", o_opposite); end
    total++; if (o_score_r !== 4'd1 || o_score_l !== 4'd0 || o_state !== 3'd3) begin bad++; $display("FAIL hitmiss_score got=%0d/%0d st=%0d want=0/1 st=3", o_score_l, o_score_r, o_state); end
    step();
    total++; if (o_opposite !== 1'b0) begin bad++; $display("FAIL hitmiss_opp_late got=%b want=0", o_opposite); end
    ticks(150);
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL hitmiss_replay got=%0d want=2", o_state); end
  endtask

  task automatic test_double_miss();
    pix(0, 1'b0, 1'b0);
    pix(1279, 1'b0, 1'b0);
    tick();
    total++; if (o_score_l !== 4'd0 || o_score_r !== 4'd2) begin bad++; $display("FAIL dblmiss_score got=%0d/%0d want=0/2", o_score_l, o_score_r); end
    ticks(150);
    total++; if (o_state !== 3'd2) begin bad++; $display("FAIL dblmiss_replay got=%0d want=2", o_state); end
  endtask

  task automatic test_game_over();
    for (int i = 1; i <= 9; i++) begin
      pix(1279, 1'b0, 1'b0);
      if (i == 9) begin
        i_start = 1'b1;
        step();
      end
      tick();
      total++; if (o_score_l !== 4'(i) || o_state !== 3'd3) begin bad++; $display("FAIL go_point%0d got=%0d st=%0d want=%0d st=3", i, o_score_l, o_state, i); end
      if (i < 9) begin
        ticks(150);
        total++; if (o_state !== 3'd2) begin bad++; $display("FAIL go_replay%0d got=%0d want=2", i, o_state); end
      end
    end
    step();
    total++; if (o_state !== 3'd4 || o_game_over !== 1'b1 || o_ball_en !== 1'b0) begin bad++; $display("FAIL go_enter got=%0d/%b/%b want=4/1/0", o_state, o_game_over, o_ball_en); end
    step();
    step();
    tick();
    total++; if (o_state !== 3'd4 || o_score_l !== 4'd9 || o_score_r !== 4'd2) begin bad++; $display("FAIL go_held got=%0d %0d/%0d want=4 9/2", o_state, o_score_l, o_score_r); end
    i_start = 1'b0;
    step();
    total++; if (o_state !== 3'd4) begin bad++; $display("FAIL go_low got=%0d want=4", o_state); end
    i_start = 1'b1;
    step();
    total++; if (o_state !== 3'd0 || o_score_l !== 4'd9) begin bad++; $display("FAIL go_idle got=%0d sl=%0d want=0 sl=9", o_state, o_score_l); end
    step();
    total++; if ({o_score_l, o_score_r} !== 8'h00) begin bad++; $display("FAIL go_clear got=%0d/%0d want=0/0", o_score_l, o_score_r); end
    i_start = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    i_vcnt       = 11'd100;
    i_hcnt       = 11'd100;
    i_start      = 1'b0;
    i_ball_draw  = 1'b0;
    i_pad_l_draw = 1'b0;
    i_pad_r_draw = 1'b0;
    test_reset();
    test_serve("serve");
    test_hit();
    test_miss_r();
    test_reset_mid();
    test_serve("restart");
    test_hit_and_miss();
    test_double_miss();
    test_game_over();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-level game sequencer for the bouncing-ball sprite in the HDMI pong demo.
- Watches the aligned pixel-draw outputs of the ball and the two paddle sprites.
- Detects paddle hits and edge misses, and issues single-cycle direction-reversal pulses to the ball's opposite input.
- Keeps per-player scores and gates ball visibility through a serve/point/game-over state machine.

Parameters:
- X_RES, 1280, active pixels per line.
- Y_RES, 720, active lines per frame.
- SERVE_FRAMES, 60, frames the ball stays hidden before play starts.
- POINT_FRAMES, 90, frames of pause after a point is scored.
- WIN_SCORE, 9, score that ends the game (1..15).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- i_vcnt  in  11  current line counter.
- i_hcnt  in  11  current pixel counter.
- i_start  in  1  level; starts or restarts a game.
- i_ball_draw  in  1  ball pixel; registered, one cycle after the counters.
- i_pad_l_draw  in  1  left paddle pixel; same alignment.
- i_pad_r_draw  in  1  right paddle pixel; same alignment.
- o_ball_en  out  1  ball visible; the top level ANDs it with i_ball_draw.
- o_opposite  out  1  one-cycle reversal pulse to the ball.
- o_score_l  out  4  left player score.
- o_score_r  out  4  right player score.
- o_game_over  out  1  high while in GAME_OVER.
- o_state  out  3  current state encoding, for debug/overlay.

Behaviour:
- Reset is synchronous and active-high. Reset values: state IDLE, scores 0, o_ball_en 0, o_opposite 0, o_game_over 0, all latches and counters 0. Reset mid-frame is honoured on the next edge; no event in flight survives it.
- Alignment: i_hcnt/i_vcnt are delayed one cycle internally (hd/vd) to match the draw inputs. All pixel tests use hd/vd.
- Frame tick: one-cycle pulse generated when i_vcnt==0 and i_hcnt==0.
- Per-frame event latches are cleared on the frame tick. Latching happens only in PLAY.
  - hit: i_ball_draw & (i_pad_l_draw | i_pad_r_draw).
  - miss_l: i_ball_draw with hd==0.
  - miss_r: i_ball_draw with hd==X_RES-1.
- Latches are sampled on the frame tick, then cleared; that is the only point where events are acted on.
- Priority: miss over hit. miss_l over miss_r, so simultaneous misses credit the right player once.
- o_opposite: asserted for exactly the one cycle after a frame tick whose sampled hit==1 and no miss. Never more than one pulse per frame. Never asserted outside PLAY.
- Frame counter: 8 bits, loaded on state entry, decremented on each frame tick, saturates at 0.
- State machine (all transitions take effect on the frame tick unless noted):
  - IDLE: o_ball_en 0. When i_start is seen (sampled any cycle), clear the scores; on the next frame tick go to SERVE.
  - SERVE: o_ball_en 0. Counter loaded SERVE_FRAMES-1. Go to PLAY on the tick where counter==0.
  - PLAY: o_ball_en 1.
    - On a miss_l tick: score_r+1, go to POINT.
    - On a miss_r tick: score_l+1, go to POINT.
    - The score increment and the state change happen in the same cycle.
  - POINT: o_ball_en 0. Counter loaded POINT_FRAMES-1.
    - If either score==WIN_SCORE, go to GAME_OVER immediately (next cycle, no frame wait).
    - Otherwise go to SERVE when counter==0.
  - GAME_OVER: o_game_over 1, o_ball_en 0. Scores frozen. A rising edge of i_start returns to IDLE; the scores clear in IDLE.
- Scores are 4-bit and saturate at 15. They cannot exceed WIN_SCORE in practice.
- i_start held high continuously does not retrigger from GAME_OVER; it is edge-detected there and level-sensitive only in IDLE.
- Encoding for o_state: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.

Decomposition:
- Shared package pong_pkg holds:
  - the state typedef and encodings (st_idle..st_game_over);
  - X_RES/Y_RES defaults;
  - the score width constant SCORE_W=4.
- One natural sub-module: pong_frame_timer, the loadable 8-bit frame-tick down-counter with a zero flag, used by SERVE and POINT.
- Event detection and the FSM stay in the top module.

Test Plan:
- Reset, then i_start=1 for one cycle:
  - IDLE until the next frame tick, then SERVE;
  - PLAY entered exactly 60 frame ticks later;
  - o_ball_en rises in the PLAY entry cycle.
- In PLAY, drive i_ball_draw and i_pad_l_draw together for 5 pixels of one frame:
  - exactly one o_opposite pulse, on the cycle after the next frame tick;
  - no score change.
- In PLAY, drive i_ball_draw with delayed hcnt==1279:
  - score_l goes 0->1 on the frame tick;
  - state POINT, o_ball_en 0;
  - SERVE after 90 ticks.
- Same frame with a hit and miss_l:
  - no o_opposite;
  - score_r+1.
- Same frame with miss_l and miss_r:
  - only score_r+1.
- Drive score_l to 9:
  - POINT then GAME_OVER the following cycle, o_game_over 1;
  - with i_start held high, stays in GAME_OVER;
  - a low-then-high i_start gives IDLE, then scores 0.
- Assert rst during SERVE mid-frame:
  - next cycle shows IDLE, scores 0, o_opposite 0, and the frame counter cleared.
